// File: rtl/resp_tx_pkg.sv
// Shared constants for the SUMP/OLS response transmitter: FSM encodings,
// ID reply, metadata keys and the reported device name.
package resp_tx_pkg;

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StSendId   = 2'd1;
    localparam logic [1:0] StSendMeta = 2'd2;
    localparam logic [1:0] StSendData = 2'd3;

    localparam logic [31:0] IdStr = 32'h31414C53;  // "1ALS"

    localparam logic [7:0] KeyDevName  = 8'h01;
    localparam logic [7:0] KeyChannels = 8'h20;
    localparam logic [7:0] KeyMemDepth = 8'h21;
    localparam logic [7:0] KeyEnd      = 8'h00;

    localparam logic [39:0] DevName = "logIP";

    localparam int unsigned IdLen   = 4;
    localparam int unsigned MetaLen = 18;

    // Byte i of a 32-bit word taken most-significant first.
    function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] i);
        logic [7:0] b;
        unique case (i)
            2'd0: b = w[31:24];
            2'd1: b = w[23:16];
            2'd2: b = w[15:8];
            2'd3: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/resp_tx_meta_rom.sv
// Combinational index-to-byte lookup for the ID reply and the metadata list.
module resp_tx_meta_rom
    import resp_tx_pkg::*;
#(
    parameter int unsigned CHANNELS  = 32,
    parameter int unsigned MEM_DEPTH = 4096
) (
    input  logic       meta_i,
    input  logic [4:0] idx_i,
    output logic [7:0] byte_o
);

    localparam logic [31:0] ChanWord  = 32'(CHANNELS);
    localparam logic [31:0] DepthWord = 32'(MEM_DEPTH);

    always_comb begin
        byte_o = 8'h00;
        if (!meta_i) begin
            byte_o = be_byte(IdStr, idx_i[1:0]);
        end else begin
            case (idx_i)
                5'd0:    byte_o = KeyDevName;
                5'd1:    byte_o = DevName[39:32];
                5'd2:    byte_o = DevName[31:24];
                5'd3:    byte_o = DevName[23:16];
                5'd4:    byte_o = DevName[15:8];
                5'd5:    byte_o = DevName[7:0];
                5'd6:    byte_o = 8'h00;
                5'd7:    byte_o = KeyChannels;
                5'd8:    byte_o = be_byte(ChanWord, 2'd0);
                5'd9:    byte_o = be_byte(ChanWord, 2'd1);
                5'd10:   byte_o = be_byte(ChanWord, 2'd2);
                5'd11:   byte_o = be_byte(ChanWord, 2'd3);
                5'd12:   byte_o = KeyMemDepth;
                5'd13:   byte_o = be_byte(DepthWord, 2'd0);
                5'd14:   byte_o = be_byte(DepthWord, 2'd1);
                5'd15:   byte_o = be_byte(DepthWord, 2'd2);
                5'd16:   byte_o = be_byte(DepthWord, 2'd3);
                5'd17:   byte_o = KeyEnd;
                default: byte_o = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/resp_tx.sv
// Response transmitter: serialises ID reply, metadata list and masked sample
// words onto the UART TX byte interface.
module resp_tx
    import resp_tx_pkg::*;
#(
    parameter int unsigned CHANNELS  = 32,
    parameter int unsigned MEM_DEPTH = 4096
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sft_rst_i,
    input  logic        id_i,
    input  logic        rd_meta_i,
    input  logic        stb_i,
    input  logic [31:0] dat_i,
    input  logic [3:0]  grp_dis_i,
    output logic        rdy_o,
    output logic [7:0]  tx_dat_o,
    output logic        tx_stb_o,
    input  logic        tx_rdy_i
);

    logic [1:0]  state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic [3:0]  rem_q, rem_d;   // byte lanes still to send
    logic [3:0]  lane_oh;
    logic        last;
    logic [7:0]  rom_byte;
    logic [7:0]  data_byte;

    resp_tx_meta_rom #(
        .CHANNELS  (CHANNELS),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_meta_rom (
        .meta_i (state_q == StSendMeta),
        .idx_i  (idx_q),
        .byte_o (rom_byte)
    );

    // Lowest pending lane; disabled lanes were never set, so they cost no cycles.
    assign lane_oh = rem_q & (~rem_q + 4'd1);

    always_comb begin
        data_byte = 8'h00;
        case (lane_oh)
            4'b0001: data_byte = word_q[7:0];
            4'b0010: data_byte = word_q[15:8];
            4'b0100: data_byte = word_q[23:16];
            4'b1000: data_byte = word_q[31:24];
            default: data_byte = 8'h00;
        endcase
    end

    always_comb begin
        last = 1'b0;
        case (state_q)
            StSendId:   last = (idx_q == 5'(IdLen - 1));
            StSendMeta: last = (idx_q == 5'(MetaLen - 1));
            StSendData: last = ((rem_q & ~lane_oh) == 4'd0);
            default:    last = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        rem_d   = rem_q;
        if (state_q == StIdle) begin
            idx_d = 5'd0;
            if (id_i) begin
                state_d = StSendId;
            end else if (rd_meta_i) begin
                state_d = StSendMeta;
            end else if (stb_i) begin
                word_d = dat_i;
                rem_d  = ~grp_dis_i;
                if (grp_dis_i != 4'hF) begin
                    state_d = StSendData;
                end
            end
        end else if (tx_rdy_i) begin
            idx_d = idx_q + 5'd1;
            rem_d = rem_q & ~lane_oh;
            if (last) begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || sft_rst_i) begin
            state_q <= StIdle;
            idx_q   <= 5'd0;
            word_q  <= 32'd0;
            rem_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        rdy_o    = (state_q == StIdle);
        tx_stb_o = (state_q != StIdle);
        tx_dat_o = 8'h00;
        case (state_q)
            StSendId, StSendMeta: tx_dat_o = rom_byte;
            StSendData:           tx_dat_o = data_byte;
            default:              tx_dat_o = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_resp_tx.sv
// Directed self-checking bench for resp_tx: ID, metadata, data masking,
// backpressure, request priority and mid-sequence resets.
module tb_resp_tx;

    typedef logic [7:0] bq_t[$];

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        sft_rst_i;
    logic        id_i;
    logic        rd_meta_i;
    logic        stb_i;
    logic [31:0] dat_i;
    logic [3:0]  grp_dis_i;
    logic        rdy_o;
    logic [7:0]  tx_dat_o;
    logic        tx_stb_o;
    logic        tx_rdy_i;

    int checks   = 0;
    int failures = 0;
    int cyc;
    int stall_viol;
    bit timed_out;
    bq_t got_q;
    bq_t exp_id   = '{8'h31, 8'h41, 8'h4C, 8'h53};
    bq_t exp_meta = '{8'h01, 8'h6C, 8'h6F, 8'h67, 8'h49, 8'h50, 8'h00, 8'h20, 8'h00,
                      8'h00, 8'h00, 8'h20, 8'h21, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
    bq_t exp_d0   = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    bq_t exp_d5   = '{8'hBE, 8'hDE};

    resp_tx #(
        .CHANNELS  (32),
        .MEM_DEPTH (4096)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .sft_rst_i (sft_rst_i),
        .id_i      (id_i),
        .rd_meta_i (rd_meta_i),
        .stb_i     (stb_i),
        .dat_i     (dat_i),
        .grp_dis_i (grp_dis_i),
        .rdy_o     (rdy_o),
        .tx_dat_o  (tx_dat_o),
        .tx_stb_o  (tx_stb_o),
        .tx_rdy_i  (tx_rdy_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; one-cycle request pulse, returns at the next negedge.
    task automatic pulse(input logic id, input logic meta, input logic stb,
                         input logic [31:0] d, input logic [3:0] dis);
        id_i      = id;
        rd_meta_i = meta;
        stb_i     = stb;
        dat_i     = d;
        grp_dis_i = dis;
        @(negedge clk_i);
        id_i      = 1'b0;
        rd_meta_i = 1'b0;
        stb_i     = 1'b0;
        dat_i     = 32'h0;
        grp_dis_i = 4'h0;
    endtask

    // Records transferred bytes until tx_stb_o drops; returns 1ns after a negedge.
    task automatic collect(input bit bp, input int max_cyc);
        logic       prev_stall;
        logic [7:0] prev_dat;
        got_q.delete();
        cyc        = 0;
        stall_viol = 0;
        timed_out  = 1'b1;
        prev_stall = 1'b0;
        prev_dat   = 8'h00;
        while (cyc < max_cyc) begin
            tx_rdy_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (!tx_stb_o) begin
                if (prev_stall) stall_viol++;
                timed_out = 1'b0;
                break;
            end
            if (prev_stall && tx_dat_o !== prev_dat) stall_viol++;
            if (tx_rdy_i) got_q.push_back(tx_dat_o);
            prev_stall = !tx_rdy_i;
            prev_dat   = tx_dat_o;
            cyc++;
            @(negedge clk_i);
        end
        tx_rdy_i = 1'b1;
        check("collect_timeout", 32'(timed_out), 32'd0);
    endtask

    task automatic check_seq(input string tag, input bq_t exp);
        check($sformatf("%s_len", tag), got_q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got_q.size()) begin
                check($sformatf("%s[%0d]", tag, i), 32'(got_q[i]), 32'(exp[i]));
            end
        end
    endtask

    initial begin
        rst_i     = 1'b1;
        sft_rst_i = 1'b0;
        id_i      = 1'b0;
        rd_meta_i = 1'b0;
        stb_i     = 1'b0;
        dat_i     = 32'h0;
        grp_dis_i = 4'h0;
        tx_rdy_i  = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("reset_stb", 32'(tx_stb_o), 32'd0);
        check("reset_dat", 32'(tx_dat_o), 32'h00);
        check("reset_rdy", 32'(rdy_o), 32'd1);

        // ID reply on consecutive cycles
        pulse(1'b1, 1'b0, 1'b0, 32'h0, 4'h0);
        check("id_rdy_low", 32'(rdy_o), 32'd0);
        collect(1'b0, 64);
        check_seq("id", exp_id);
        check("id_cycles", cyc, 32'd4);
        check("id_rdy_after", 32'(rdy_o), 32'd1);

        // Metadata list
        pulse(1'b0, 1'b1, 1'b0, 32'h0, 4'h0);
        collect(1'b0, 64);
        check_seq("meta", exp_meta);
        check("meta_cycles", cyc, 32'd18);
        check("meta_rdy_after", 32'(rdy_o), 32'd1);

        // Data masking
        pulse(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 4'b0000);
        collect(1'b0, 64);
        check_seq("data0", exp_d0);
        pulse(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 4'b0101);
        collect(1'b0, 64);
        check_seq("data5", exp_d5);
        check("data5_cycles", cyc, 32'd2);
        pulse(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 4'b1111);
        #1;
        check("dataF_stb", 32'(tx_stb_o), 32'd0);
        check("dataF_rdy", 32'(rdy_o), 32'd1);
        @(negedge clk_i);

        // Backpressure on metadata
        pulse(1'b0, 1'b1, 1'b0, 32'h0, 4'h0);
        collect(1'b1, 400);
        check_seq("meta_bp", exp_meta);
        check("meta_bp_stable", stall_viol, 32'd0);
        @(negedge clk_i);

        // Priority: id wins over meta and data
        pulse(1'b1, 1'b1, 1'b1, 32'h12345678, 4'h0);
        collect(1'b0, 64);
        check_seq("prio", exp_id);
        @(negedge clk_i);

        // Data strobe while busy is ignored
        id_i = 1'b1;
        @(negedge clk_i);
        id_i      = 1'b0;
        tx_rdy_i  = 1'b0;
        stb_i     = 1'b1;
        dat_i     = 32'hCAFEF00D;
        @(negedge clk_i);
        stb_i = 1'b0;
        collect(1'b0, 64);
        check_seq("busy", exp_id);
        @(negedge clk_i);
        #1;
        check("busy_no_data", 32'(tx_stb_o), 32'd0);

        // Soft reset then hard reset, each after five metadata bytes
        for (int r = 0; r < 2; r++) begin
            @(negedge clk_i);
            pulse(1'b0, 1'b1, 1'b0, 32'h0, 4'h0);
            tx_rdy_i = 1'b1;
            repeat (5) @(negedge clk_i);
            #1;
            check($sformatf("rst%0d_pre_dat", r), 32'(tx_dat_o), 32'h50);
            if (r == 0) sft_rst_i = 1'b1;
            else rst_i = 1'b1;
            @(negedge clk_i);
            sft_rst_i = 1'b0;
            rst_i     = 1'b0;
            #1;
            check($sformatf("rst%0d_stb", r), 32'(tx_stb_o), 32'd0);
            check($sformatf("rst%0d_rdy", r), 32'(rdy_o), 32'd1);
            check($sformatf("rst%0d_dat", r), 32'(tx_dat_o), 32'h00);
            @(negedge clk_i);
            pulse(1'b1, 1'b0, 1'b0, 32'h0, 4'h0);
            collect(1'b0, 64);
            check_seq($sformatf("rst%0d_id", r), exp_id);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
